// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: FSM encoding, requester bounds,
// grant-index type and the i2c master's state encoding.
package i2c_pkg;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT_DONE,
    ST_RELEASE
  } arb_state_e;

  // Encoding used by the i2c master this arbiter fronts.
  typedef enum logic [2:0] {
    M_ST_IDLE,
    M_ST_START,
    M_ST_ADDR,
    M_ST_DATA,
    M_ST_ACK,
    M_ST_STOP
  } mst_state_e;

  function automatic bit n_req_ok(input int n);
    return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
  endfunction

  // Next round-robin start position after requester i was served.
  function automatic idx_t wrap_inc(input idx_t i, input int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester found searching from ptr
// upward, wrapping to 0.
module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic [N_REQ-1:0] gnt,
  output idx_t             idx,
  output logic             valid
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // Upper segment [ptr, N_REQ) has priority over the wrapped segment [0, ptr).
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[k] && (k >= int'(ptr))) begin
        valid  = 1'b1;
        idx    = IDX_W'(k);
        gnt[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[k]) begin
        valid  = 1'b1;
        idx    = IDX_W'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c master between N_REQ requesters: round-robin grant, command
// latching, per-transaction timeout with master abort, and FIFO strobe routing.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TO_W  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr_rw,
  input  logic [8*N_REQ-1:0] req_cnt,
  input  logic [N_REQ-1:0]   req_txff_empty,
  input  logic [N_REQ-1:0]   req_rxff_full,
  output logic [N_REQ-1:0]   req_txff_rd,
  output logic [N_REQ-1:0]   req_rxff_wr,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   req_done,
  output logic               m_ready,
  output logic [7:0]         m_addr_rw,
  output logic [7:0]         m_cnt,
  output logic               m_txff_empty,
  output logic               m_rxff_full,
  input  logic               m_done,
  input  logic               m_txff_rd,
  input  logic               m_rxff_wr,
  output logic               m_abort,
  input  logic [TO_W-1:0]    timeout_cycles,
  output logic               err_timeout,
  input  logic               err_clr
);

  if (!n_req_ok(N_REQ)) begin : g_bad_n_req
    $error("i2c_req_arbiter: N_REQ out of range");
  end

  arb_state_e       state_q, state_d;
  idx_t             ptr_q, ptr_d;
  idx_t             idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] req_done_q, req_done_d;
  logic             m_ready_q, m_ready_d;
  logic [7:0]       m_addr_rw_q, m_addr_rw_d;
  logic [7:0]       m_cnt_q, m_cnt_d;
  logic             m_abort_q, m_abort_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  idx_t             arb_idx;
  logic             arb_valid;
  logic [7:0]       addr_sel, cnt_sel;
  logic             to_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One-hot mux of the winner's command fields.
  always_comb begin
    addr_sel = '0;
    cnt_sel  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        addr_sel = req_addr_rw[8*k +: 8];
        cnt_sel  = req_cnt[8*k +: 8];
      end
    end
  end

  // Counter holds the number of completed WAIT_DONE cycles, so the limit is hit
  // during WAIT_DONE cycle number timeout_cycles.
  assign to_hit = (timeout_cycles != '0) && (to_cnt_q >= timeout_cycles - 1'b1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    req_done_d  = '0;
    m_ready_d   = m_ready_q;
    m_addr_rw_d = m_addr_rw_q;
    m_cnt_d     = m_cnt_q;
    m_abort_d   = 1'b0;
    err_d       = err_q & ~err_clr;
    to_cnt_d    = to_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        to_cnt_d = '0;
        if (arb_valid) begin
          idx_d       = arb_idx;
          gnt_d       = arb_gnt;
          m_ready_d   = 1'b1;
          m_addr_rw_d = addr_sel;
          m_cnt_d     = cnt_sel;
          state_d     = ST_WAIT_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (~&to_cnt_q) to_cnt_d = to_cnt_q + 1'b1;
        // m_done has priority over a simultaneous timeout.
        if (m_done || to_hit) begin
          m_ready_d  = 1'b0;
          req_done_d = gnt_q;
          state_d    = ST_RELEASE;
          if (!m_done) begin
            m_abort_d = 1'b1;
            err_d     = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        ptr_d   = wrap_inc(idx_q, N_REQ);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      req_done_q  <= '0;
      m_ready_q   <= 1'b0;
      m_addr_rw_q <= '0;
      m_cnt_q     <= '0;
      m_abort_q   <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      req_done_q  <= req_done_d;
      m_ready_q   <= m_ready_d;
      m_addr_rw_q <= m_addr_rw_d;
      m_cnt_q     <= m_cnt_d;
      m_abort_q   <= m_abort_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign req_done    = req_done_q;
  assign m_ready     = m_ready_q;
  assign m_addr_rw   = m_addr_rw_q;
  assign m_cnt       = m_cnt_q;
  assign m_abort     = m_abort_q;
  assign err_timeout = err_q;

  // Routing follows the registered grant, so an async reset detaches the master at once.
  assign m_txff_empty = (|gnt_q) ? |(gnt_q & req_txff_empty) : 1'b1;
  assign m_rxff_full  = (|gnt_q) ? |(gnt_q & req_rxff_full)  : 1'b1;
  assign req_txff_rd  = gnt_q & {N_REQ{m_txff_rd}};
  assign req_rxff_wr  = gnt_q & {N_REQ{m_rxff_wr}};

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: table of transactions plus hand-written
// sequences for routing, timeout, drop-in-ARB and async reset.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int TW = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_addr_rw, req_cnt;
  logic [N-1:0]   req_txff_empty, req_rxff_full;
  logic [N-1:0]   req_txff_rd, req_rxff_wr, gnt, req_done;
  logic           m_ready, m_txff_empty, m_rxff_full, m_abort, err_timeout;
  logic [7:0]     m_addr_rw, m_cnt;
  logic           m_done, m_txff_rd, m_rxff_wr, err_clr;
  logic [TW-1:0]  timeout_cycles;

  i2c_req_arbiter #(.N_REQ(N), .TO_W(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_addr_rw    (req_addr_rw),
    .req_cnt        (req_cnt),
    .req_txff_empty (req_txff_empty),
    .req_rxff_full  (req_rxff_full),
    .req_txff_rd    (req_txff_rd),
    .req_rxff_wr    (req_rxff_wr),
    .gnt            (gnt),
    .req_done       (req_done),
    .m_ready        (m_ready),
    .m_addr_rw      (m_addr_rw),
    .m_cnt          (m_cnt),
    .m_txff_empty   (m_txff_empty),
    .m_rxff_full    (m_rxff_full),
    .m_done         (m_done),
    .m_txff_rd      (m_txff_rd),
    .m_rxff_wr      (m_rxff_wr),
    .m_abort        (m_abort),
    .timeout_cycles (timeout_cycles),
    .err_timeout    (err_timeout),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [7:0]   addr;
    logic [7:0]   cnt;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    int           done_wait;
    int           exp_idx;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  logic [7:0] addr_tab[N];
  logic [7:0] cnt_tab[N];
  int         checks   = 0;
  int         failures = 0;
  bit         prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int idx);
    exp_t e;
    e.gnt  = N'(1) << idx;
    e.addr = addr_tab[idx];
    e.cnt  = cnt_tab[idx];
    sb.push_back(e);
  endtask

  // Scoreboard: each new grant (rising m_ready) is matched against the oldest expectation.
  always @(negedge clk) begin
    if (m_ready && !prev_ready) begin
      check("grant_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("grant_onehot", 32'(gnt), 32'(e.gnt));
        check("grant_addr", 32'(m_addr_rw), 32'(e.addr));
        check("grant_cnt", 32'(m_cnt), 32'(e.cnt));
      end
    end
    prev_ready = m_ready;
  end

  task automatic wait_grant();
    int n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 32'(m_ready), 1);
  endtask

  // Called at the negedge of the WAIT_DONE cycle in which the master reports done.
  task automatic finish_txn(input int idx);
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    check("release_req_done", 32'(req_done), 32'(N'(1) << idx));
    check("release_gnt", 32'(gnt), 32'(N'(1) << idx));
    check("release_ready", 32'(m_ready), 0);
    check("release_no_abort", 32'(m_abort), 0);
    @(negedge clk);
    check("idle_req_done", 32'(req_done), 0);
    check("idle_gnt", 32'(gnt), 0);
    req = '0;
  endtask

  task automatic run_txn(input logic [N-1:0] r, input int done_wait, input int idx);
    bit held = 1'b1;
    req = r;
    expect_grant(idx);
    wait_grant();
    for (int c = 1; c < done_wait; c++) begin
      @(negedge clk);
      if (!m_ready || gnt !== (N'(1) << idx)) held = 1'b0;
    end
    check("ready_held", 32'(held), 1);
    finish_txn(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n, rd1, rd_oth, wr1, wr_oth, bad;

    addr_tab = '{8'h12, 8'h56, 8'hA0, 8'h31};
    cnt_tab  = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int k = 0; k < N; k++) begin
      req_addr_rw[8*k +: 8] = addr_tab[k];
      req_cnt[8*k +: 8]     = cnt_tab[k];
    end
    // Rotation from ptr 0, then mixed patterns continuing from the rotated pointer.
    vecs = '{
      '{4'b1111, 3, 0}, '{4'b1111, 1, 1}, '{4'b1111, 2, 2}, '{4'b1111, 4, 3},
      '{4'b1111, 2, 0}, '{4'b0100, 5, 2}, '{4'b0110, 2, 1}, '{4'b1001, 3, 3}
    };

    rst = 1'b0; req = '0; req_txff_empty = '0; req_rxff_full = '0;
    m_done = 1'b0; m_txff_rd = 1'b0; m_rxff_wr = 1'b0; err_clr = 1'b0;
    timeout_cycles = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ready", 32'(m_ready), 0);
    check("rst_req_done", 32'(req_done), 0);
    check("rst_addr", 32'(m_addr_rw), 0);
    check("rst_cnt", 32'(m_cnt), 0);
    check("rst_abort", 32'(m_abort), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_txff_empty", 32'(m_txff_empty), 1);
    check("rst_rxff_full", 32'(m_rxff_full), 1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i].req, vecs[i].done_wait, vecs[i].exp_idx);

    // Routing while requester 1 holds the grant; its req changes are ignored.
    req = 4'b0010;
    expect_grant(1);
    wait_grant();
    req = 4'b1000;
    rd1 = 0; rd_oth = 0; wr1 = 0; wr_oth = 0;
    for (int i = 0; i < 8; i++) begin
      m_txff_rd = (i % 2 == 0);
      m_rxff_wr = (i == 3);
      #1;
      if (req_txff_rd[1]) rd1++;
      if ((req_txff_rd & 4'b1101) != 0) rd_oth++;
      if (req_rxff_wr[1]) wr1++;
      if ((req_rxff_wr & 4'b1101) != 0) wr_oth++;
      @(negedge clk);
    end
    m_txff_rd = 1'b0; m_rxff_wr = 1'b0;
    check("route_txrd_k1", 32'(rd1), 4);
    check("route_txrd_other", 32'(rd_oth), 0);
    check("route_rxwr_k1", 32'(wr1), 1);
    check("route_rxwr_other", 32'(wr_oth), 0);
    check("held_gnt", 32'(gnt), 32'(4'b0010));
    check("held_addr", 32'(m_addr_rw), 32'(8'h56));
    req_txff_empty = 4'b1101; #1 check("route_txe_0", 32'(m_txff_empty), 0);
    req_txff_empty = 4'b0010; #1 check("route_txe_1", 32'(m_txff_empty), 1);
    req_rxff_full  = 4'b0010; #1 check("route_rxf_1", 32'(m_rxff_full), 1);
    req_rxff_full  = 4'b1101; #1 check("route_rxf_0", 32'(m_rxff_full), 0);
    req_txff_empty = '0; req_rxff_full = '0;
    @(negedge clk);
    finish_txn(1);
    m_txff_rd = 1'b1;
    #1 check("ungranted_txrd", 32'(req_txff_rd), 0);
    check("ungranted_txe", 32'(m_txff_empty), 1);
    m_txff_rd = 1'b0;

    // Timeout on requester 2 (err_clr held: set must win), then 3 is served.
    timeout_cycles = TW'(100);
    err_clr = 1'b1;
    req = 4'b1100;
    expect_grant(2);
    expect_grant(3);
    wait_grant();
    cnt = 1; n = 0;
    while (!m_abort && n < 300) begin
      @(negedge clk);
      n++;
      if (m_ready) cnt++;
    end
    check("abort_seen", 32'(m_abort), 1);
    check("abort_wait_cycles", 32'(cnt), 100);
    check("abort_err_set", 32'(err_timeout), 1);
    check("abort_req_done", 32'(req_done), 32'(4'b0100));
    err_clr = 1'b0;
    @(negedge clk);
    check("abort_one_pulse", 32'(m_abort), 0);
    check("err_sticky", 32'(err_timeout), 1);
    wait_grant();
    @(negedge clk);
    finish_txn(3);
    check("err_still_set", 32'(err_timeout), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 32'(err_timeout), 0);

    // m_done in exactly the timeout cycle: no abort, no error.
    timeout_cycles = TW'(5);
    req = 4'b0001;
    expect_grant(0);
    wait_grant();
    repeat (4) @(negedge clk);
    check("coincide_ready", 32'(m_ready), 1);
    finish_txn(0);
    check("coincide_no_err", 32'(err_timeout), 0);

    // req vanishes during ARB: back to IDLE with no grant.
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnt != 0 || m_ready) bad++;
    end
    check("drop_no_grant", 32'(bad), 0);

    // Timeout disabled: a long transaction runs to m_done.
    timeout_cycles = '0;
    run_txn(4'b0010, 30, 1);

    // Async reset mid-transaction.
    req = 4'b0100;
    expect_grant(2);
    wait_grant();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 0);
    check("arst_ready", 32'(m_ready), 0);
    check("arst_addr", 32'(m_addr_rw), 0);
    req = '0;
    @(negedge clk);
    check("arst_no_req_done", 32'(req_done), 0);
    rst = 1'b1;
    @(negedge clk);
    run_txn(4'b0110, 2, 1);
    run_txn(4'b1000, 2, 3);

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
